rijndael_mask_seq_m: RTL and testbench
======================================

Name: rijndael_mask_seq_m

Overview:
Upstream sequencer for the masked Rijndael S-box stage (two-state LOAD/BSUB S-box FSM).
- Accepts plaintext/key bytes over a valid/ready handshake.
- Draws fresh input/output masks from a free-running 16-bit LFSR.
- Issues exactly one valid pulse to the S-box stage and holds all S-box operands stable until the result is captured.
- Presents the unmasked result with a valid/ready handshake, plus a scope trigger for DPA trace acquisition.

Parameters:
LATENCY, 2, cycles from the sb_valid cycle until sb_dout is captured (the S-box stage needs LOAD then BSUB, so dout is valid 2 cycles after valid)
SEED_DEFAULT, 16'hACE1, LFSR value after reset and on a zero seed load
LFSR_TAPS, 16'hB400, Galois LFSR feedback mask (x^16+x^14+x^13+x^11+1)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset; synchronous, active-low (asserted when 0 at posedge clk)
seed_load  in  1  load LFSR from seed this cycle
seed  in  16  LFSR seed value
mask_en  in  1  1: masks from LFSR; 0: masks forced to 8'h00
pt_valid  in  1  plaintext byte offered
pt_ready  out  1  sequencer accepts plaintext this cycle
pt  in  8  plaintext byte
key  in  8  key byte
sb_valid  out  1  valid to S-box stage
sb_din  out  8  plaintext to S-box stage
sb_key  out  8  key to S-box stage
sb_imask  out  8  input mask to S-box stage
sb_omask  out  8  output mask to S-box stage
sb_dout  in  8  unmasked S-box result from S-box stage
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res  out  8  captured S-box result
trig  out  1  scope trigger, high while the S-box computes

Behaviour:
Reset (rst=0 at posedge):
- State IDLE.
- LFSR = SEED_DEFAULT.
- sb_din, sb_key, sb_imask, sb_omask and res = 0.
- sb_valid, res_valid and trig = 0; pt_ready = 1.
- Reset mid-operation abandons the op. No res_valid is produced and no further sb_valid is issued.

LFSR:
- Advances one Galois step every cycle: lfsr = (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
- seed_load has priority over stepping in any state: lfsr = seed, or SEED_DEFAULT if seed==0, so the LFSR never locks up.

States IDLE, ISSUE, WAIT, DONE. The S-box operand registers change only on accept.
- IDLE: pt_ready=1. On pt_valid, capture the following and go to ISSUE:
  - sb_din=pt, sb_key=key.
  - sb_imask = mask_en ? lfsr[7:0] : 0.
  - sb_omask = mask_en ? lfsr[15:8] : 0.
- ISSUE: sb_valid=1 for exactly this one cycle. Load count=LATENCY-1, go to WAIT.
- WAIT: trig=1. Decrement count each cycle. When count==0: res <= sb_dout, go to DONE.
- DONE: res_valid=1, pt_ready=0. Hold res until res_ready. Same-cycle res_ready is taken immediately; go to IDLE.

Timing and throughput:
- Accept at cycle A gives sb_valid at A+1, trig at A+2..A+3, res_valid from A+4.
- Throughput is 1 op per 5 cycles with res_ready tied high.

Handshake and stability rules:
- pt_valid outside IDLE is ignored.
- sb_valid never reasserts before DONE exits, which guarantees the S-box stage is back in LOAD.
- sb_omask and sb_imask are held from accept through DONE. Required because S-box dout XORs with the live omask input.
- mask_en and seed_load mid-op do not affect the in-flight op's masks.

Decomposition:
- Package rijndael_seq_pkg: state enum {IDLE, ISSUE, WAIT, DONE}, SEED_DEFAULT, LFSR_TAPS, LATENCY default.
- One sub-module, mask_lfsr16_m: seed_load/seed/step-every-cycle LFSR with zero-seed guard.

Test Plan:
- mask_en=0, pt=8'h00, key=8'h00 -> sb_imask=sb_omask=0, sb_valid single pulse at A+1, res=8'h63 with res_valid at A+4.
- mask_en=1 after reset, pt=8'h12, key=8'h34 -> sb_imask/sb_omask equal the LFSR bytes at accept (nonzero), res=8'hF7; repeat 256 random pt/key pairs, res always equals SBOX(pt^key).
- res_ready low for 5 cycles after res_valid -> res and res_valid held, pt_ready=0, no second sb_valid, trig low in DONE; res_ready=1 -> IDLE next cycle.
- rst=0 during WAIT -> next cycle all outputs at reset values, res_valid never asserts; next op pt=8'h53, key=0, mask_en=0 -> res=8'hED.
- seed_load=1, seed=16'h0000 -> lfsr=16'hACE1; seed=16'h0001 then accept same cycle+1 -> masks from one-step successor of 16'h0001 (16'hB400): imask=8'h00, omask=8'hB4.
- pt_valid held high continuously, res_ready=1 -> one accept every 5 cycles, sb_valid pulses exactly 5 cycles apart.

Source files
------------

// File: rtl/rijndael_seq_pkg.sv
// Shared types and constants for the masked Rijndael S-box sequencer.
package rijndael_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [15:0] SEED_DEFAULT    = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS       = 16'hB400;
    localparam int          LATENCY_DEFAULT = 2;

endpackage

// File: rtl/mask_lfsr16_m.sv
// Free-running 16-bit Galois LFSR supplying fresh mask material every cycle.
module mask_lfsr16_m
    import rijndael_seq_pkg::*;
#(
    parameter logic [15:0] SEED_INIT = SEED_DEFAULT,
    parameter logic [15:0] TAPS      = LFSR_TAPS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
        // A zero seed would freeze the register, so substitute the default.
        if (seed_load) begin
            lfsr_d = (seed == 16'h0000) ? SEED_INIT : seed;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= SEED_INIT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/rijndael_mask_seq_m.sv
// Sequencer feeding one masked operation at a time into the two-state S-box
// stage and returning its unmasked result over a valid/ready handshake.
module rijndael_mask_seq_m
    import rijndael_seq_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        mask_en,
    input  logic        pt_valid,
    output logic        pt_ready,
    input  logic [7:0]  pt,
    input  logic [7:0]  key,
    output logic        sb_valid,
    output logic [7:0]  sb_din,
    output logic [7:0]  sb_key,
    output logic [7:0]  sb_imask,
    output logic [7:0]  sb_omask,
    input  logic [7:0]  sb_dout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res,
    output logic        trig
);

    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       din_q, din_d;
    logic [7:0]       key_q, key_d;
    logic [7:0]       imask_q, imask_d;
    logic [7:0]       omask_q, omask_d;
    logic [7:0]       res_q, res_d;
    logic [15:0]      lfsr;

    mask_lfsr16_m u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .lfsr      (lfsr)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        din_d     = din_q;
        key_d     = key_q;
        imask_d   = imask_q;
        omask_d   = omask_q;
        res_d     = res_q;
        pt_ready  = 1'b0;
        sb_valid  = 1'b0;
        trig      = 1'b0;
        res_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                pt_ready = 1'b1;
                // Operands and masks freeze here; the S-box output XORs with
                // the live omask, so nothing may move until DONE exits.
                if (pt_valid) begin
                    din_d   = pt;
                    key_d   = key;
                    imask_d = mask_en ? lfsr[7:0]  : 8'h00;
                    omask_d = mask_en ? lfsr[15:8] : 8'h00;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                sb_valid = 1'b1;
                cnt_d    = CNT_W'(LATENCY - 1);
                state_d  = WAIT;
            end
            WAIT: begin
                trig = 1'b1;
                if (cnt_q == '0) begin
                    res_d   = sb_dout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            din_q   <= 8'h00;
            key_q   <= 8'h00;
            imask_q <= 8'h00;
            omask_q <= 8'h00;
            res_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            key_q   <= key_d;
            imask_q <= imask_d;
            omask_q <= omask_d;
            res_q   <= res_d;
        end
    end

    assign sb_din   = din_q;
    assign sb_key   = key_q;
    assign sb_imask = imask_q;
    assign sb_omask = omask_q;
    assign res      = res_q;

endmodule

// File: tb/tb_rijndael_mask_seq_m.sv
// Randomized self-checking bench for rijndael_mask_seq_m with a behavioural
// S-box stage and mask LFSR reference.
module tb_rijndael_mask_seq_m;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        mask_en = 1'b0;
    logic        pt_valid = 1'b0;
    logic        pt_ready;
    logic [7:0]  pt = 8'h00;
    logic [7:0]  key = 8'h00;
    logic        sb_valid;
    logic [7:0]  sb_din, sb_key, sb_imask, sb_omask;
    logic [7:0]  sb_dout;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res;
    logic        trig;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  sbox_tab [256];
    logic [15:0] lfsr_m = 16'hACE1;

    always #5 clk = ~clk;

    rijndael_mask_seq_m dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .mask_en   (mask_en),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready),
        .pt        (pt),
        .key       (key),
        .sb_valid  (sb_valid),
        .sb_din    (sb_din),
        .sb_key    (sb_key),
        .sb_imask  (sb_imask),
        .sb_omask  (sb_omask),
        .sb_dout   (sb_dout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res),
        .trig      (trig)
    );

    // Reference mask generator: plain Galois stepping with seed override.
    always @(posedge clk) begin
        if (!rst)
            lfsr_m <= 16'hACE1;
        else if (seed_load)
            lfsr_m <= (seed == 16'h0000) ? 16'hACE1 : seed;
        else
            lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    // S-box stage model: LOAD latches the masked result, two cycles after
    // valid it is unmasked with the live omask; otherwise dout is noise.
    logic       sbv1 = 1'b0;
    logic       sbv2 = 1'b0;
    logic [7:0] sb_masked = 8'h00;
    logic [7:0] noise = 8'h5C;
    always @(posedge clk) begin
        sbv1  <= sb_valid;
        sbv2  <= sbv1;
        noise <= 8'($urandom);
        if (sb_valid) sb_masked <= sbox_tab[sb_din ^ sb_key] ^ sb_omask;
    end
    assign sb_dout = sbv2 ? (sb_masked ^ sb_omask) : noise;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'h00;
        for (int b = 1; b < 256; b++)
            if (v != 8'h00 && gmul(v, 8'(b)) == 8'h01) inv = 8'(b);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_pt_ready", pt_ready, 1);
        chk("rst_sb_valid", sb_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_trig", trig, 0);
        chk("rst_sb_din", sb_din, 0);
        chk("rst_sb_key", sb_key, 0);
        chk("rst_sb_imask", sb_imask, 0);
        chk("rst_sb_omask", sb_omask, 0);
        chk("rst_res", res, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0; pt_valid = 1'b0; seed_load = 1'b0; res_ready = 1'b0; mask_en = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge of an IDLE cycle; returns at the negedge of the
    // IDLE cycle following DONE.
    task automatic run_op(input logic [7:0] p, input logic [7:0] k, input logic men,
                          input int hold, input logic disturb, input logic [7:0] exp_res,
                          output logic [7:0] im_o, output logic [7:0] om_o);
        logic [7:0] eim, eom;
        chk("idle_pt_ready", pt_ready, 1);
        pt_valid = 1'b1; pt = p; key = k; mask_en = men; res_ready = 1'b0;
        eim = men ? lfsr_m[7:0]  : 8'h00;
        eom = men ? lfsr_m[15:8] : 8'h00;
        @(negedge clk);
        pt_valid = 1'b0;
        chk("issue_sb_valid", sb_valid, 1);
        chk("issue_sb_din", sb_din, p);
        chk("issue_sb_key", sb_key, k);
        chk("issue_imask", sb_imask, eim);
        chk("issue_omask", sb_omask, eom);
        chk("issue_trig", trig, 0);
        chk("issue_pt_ready", pt_ready, 0);
        im_o = sb_imask; om_o = sb_omask;
        if (disturb) begin
            pt_valid = 1'b1; pt = 8'($urandom); key = 8'($urandom);
            mask_en = 1'($urandom); seed_load = 1'($urandom); seed = 16'($urandom);
        end
        @(negedge clk);
        chk("wait1_sb_valid", sb_valid, 0);
        chk("wait1_trig", trig, 1);
        @(negedge clk);
        chk("wait2_sb_valid", sb_valid, 0);
        chk("wait2_trig", trig, 1);
        pt_valid = 1'b0; seed_load = 1'b0;
        @(negedge clk);
        for (int h = 0; h <= hold; h++) begin
            chk("done_res_valid", res_valid, 1);
            chk("done_res", res, exp_res);
            chk("done_pt_ready", pt_ready, 0);
            chk("done_sb_valid", sb_valid, 0);
            chk("done_trig", trig, 0);
            chk("done_masks", {sb_imask, sb_omask, sb_din}, {eim, eom, p});
            if (h == hold) res_ready = 1'b1;
            @(negedge clk);
        end
        res_ready = 1'b0;
        chk("exit_res_valid", res_valid, 0);
        chk("exit_pt_ready", pt_ready, 1);
    endtask

    initial begin
        logic [7:0] im, om, rp, rk;
        int pulses, last;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

        do_reset();

        run_op(8'h00, 8'h00, 1'b0, 0, 1'b0, 8'h63, im, om);
        chk("unmasked_im", im, 0);
        chk("unmasked_om", om, 0);

        do_reset();
        run_op(8'h12, 8'h34, 1'b1, 0, 1'b0, 8'hF7, im, om);
        chk("masked_nonzero", (im | om) != 8'h00, 1);

        run_op(8'hC3, 8'h19, 1'b1, 5, 1'b1, sbox_tab[8'hC3 ^ 8'h19], im, om);

        // Reset while the S-box computes.
        chk("pre_rst_ready", pt_ready, 1);
        pt_valid = 1'b1; pt = 8'h77; key = 8'h21; mask_en = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        pt_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_trig", trig, 1);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_quiet", {res_valid, sb_valid}, 2'b00);
            @(negedge clk);
        end
        res_ready = 1'b0;
        run_op(8'h53, 8'h00, 1'b0, 0, 1'b0, 8'hED, im, om);

        // Seed loading.
        seed_load = 1'b1; seed = 16'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        run_op(8'hA5, 8'h5A, 1'b1, 0, 1'b0, sbox_tab[8'hFF], im, om);
        chk("zero_seed_im", im, 8'hE1);
        chk("zero_seed_om", om, 8'hAC);
        seed_load = 1'b1; seed = 16'h0001;
        @(negedge clk);
        seed_load = 1'b0;
        @(negedge clk);
        run_op(8'h3C, 8'h0F, 1'b1, 0, 1'b0, sbox_tab[8'h33], im, om);
        chk("seed1_im", im, 8'h00);
        chk("seed1_om", om, 8'hB4);

        // Back-to-back throughput with both handshakes held high.
        pulses = 0; last = 0;
        pt_valid = 1'b1; pt = 8'h9A; key = 8'h01; mask_en = 1'b1; res_ready = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (sb_valid) begin
                if (pulses == 0) chk("tput_first", i, 1);
                else             chk("tput_gap", i - last, 5);
                pulses++; last = i;
            end
            if (res_valid) chk("tput_res", res, sbox_tab[8'h9B]);
            if (i == 39) pt_valid = 1'b0;
        end
        res_ready = 1'b0;
        chk("tput_pulses", pulses, 8);
        chk("tput_idle", pt_ready, 1);

        for (int n = 0; n < 256; n++) begin
            rp = 8'($urandom); rk = 8'($urandom);
            run_op(rp, rk, 1'($urandom), $urandom_range(0, 2), 1'($urandom),
                   sbox_tab[rp ^ rk], im, om);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
